// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: valid/ready SLL/SRL/SRA/ROR shifter, one mux stage per shift-amount bit
module pipelined_barrel_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH),
   parameter int PIPE    = 1,
   parameter int TAG_W   = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag
);
   localparam int N = PIPE != 0 ? SHAMT_W : 1;
   logic [N-1:0] v;
   logic [N:0] ld;
   logic [WIDTH-1:0] d [N];
   logic [SHAMT_W-1:0] s [N];
   logic [1:0] o [N];
   logic [TAG_W-1:0] t [N];
   logic [N-1:0] sv;
   logic [WIDTH-1:0] sd [N];
   logic [SHAMT_W-1:0] ss [N];
   logic [1:0] so [N];
   logic [TAG_W-1:0] st [N];
   // Applies mux stages lo..hi-1; SRA keeps the MSB, which always equals the operand's original sign.
   function automatic logic [WIDTH-1:0] shift_fn(input logic [WIDTH-1:0] x, input logic [SHAMT_W-1:0] sa,
                                                 input logic [1:0] op, input int lo, input int hi);
      logic [WIDTH-1:0] r;
      r = x;
      for (int k = 0; k < SHAMT_W; k++)
         if (k >= lo && k < hi && sa[k])
            r = op == 2'b00 ? r << (1 << k) :
                op == 2'b01 ? r >> (1 << k) :
                op == 2'b10 ? WIDTH'($signed(r) >>> (1 << k)) :
                (r >> (1 << k)) | (r << (WIDTH - (1 << k)));
      return r;
   endfunction
   always_comb begin
      ld[N] = out_ready;
      for (int j = N - 1; j >= 0; j--) ld[j] = !v[j] || ld[j+1];
      sv[0] = in_valid;
      sd[0] = in_data;
      ss[0] = in_shamt;
      so[0] = in_op;
      st[0] = in_tag;
      for (int j = 1; j < N; j++) begin
         sv[j] = v[j-1];
         sd[j] = d[j-1];
         ss[j] = s[j-1];
         so[j] = o[j-1];
         st[j] = t[j-1];
      end
   end
   // Payload only updates on a valid load, so idle-input values never reach the outputs.
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         v <= '0;
         for (int j = 0; j < N; j++) begin
            d[j] <= '0;
            s[j] <= '0;
            o[j] <= '0;
            t[j] <= '0;
         end
      end else
         for (int j = 0; j < N; j++)
            if (ld[j]) begin
               v[j] <= sv[j];
               if (sv[j]) begin
                  d[j] <= shift_fn(sd[j], ss[j], so[j], PIPE != 0 ? j : 0, PIPE != 0 ? j + 1 : SHAMT_W);
                  s[j] <= ss[j];
                  o[j] <= so[j];
                  t[j] <= st[j];
               end
            end
   assign in_ready  = ld[0];
   assign out_valid = v[N-1];
   assign out_data  = d[N-1];
   assign out_tag   = t[N-1];
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed table, streaming, backpressure, random and reset tests
// on a 32-bit PIPE=1 instance and an 8-bit PIPE=0 instance sharing clock and reset.
module tb_pipelined_barrel_shifter;
   localparam int TW = 6;
   logic clk = 0, rst = 0;
   always #5 clk = ~clk;
   int tests = 0, fails = 0;

   logic a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [31:0] a_in_data, a_out_data;
   logic [4:0] a_in_shamt;
   logic [1:0] a_in_op;
   logic [TW-1:0] a_in_tag, a_out_tag;
   logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [7:0] b_in_data, b_out_data;
   logic [2:0] b_in_shamt;
   logic [1:0] b_in_op;
   logic [TW-1:0] b_in_tag, b_out_tag;

   pipelined_barrel_shifter #(.WIDTH(32), .PIPE(1), .TAG_W(TW)) dut_a (
      .clock(clk), .reset(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_shamt(a_in_shamt), .in_op(a_in_op), .in_tag(a_in_tag), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_data(a_out_data), .out_tag(a_out_tag));
   pipelined_barrel_shifter #(.WIDTH(8), .PIPE(0), .TAG_W(TW)) dut_b (
      .clock(clk), .reset(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_shamt(b_in_shamt), .in_op(b_in_op), .in_tag(b_in_tag), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag));

   typedef struct {logic [31:0] d; logic [TW-1:0] t;} exp_t;
   typedef struct {bit b; logic [31:0] d; int sh; logic [1:0] op; logic [31:0] exp;} vec_t;
   exp_t qa[$], qb[$];
   exp_t ea, eb;
   vec_t vt [20];

   // Reference: whole-operand arithmetic on a w-bit value held in 64 bits.
   function automatic logic [31:0] ref_shift(input logic [31:0] x, input int n, input logic [1:0] op, input int w);
      longint unsigned m, val, r;
      m = (64'd1 << w) - 1;
      val = {32'd0, x} & m;
      case (op)
         2'b00:   r = val << n;
         2'b01:   r = val >> n;
         2'b10:   r = val[w-1] ? ((val >> n) | (m & ~(m >> n))) : (val >> n);
         default: r = (val >> n) | (val << (w - n));
      endcase
      return 32'(r & m);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic ov(input bit b); return b ? b_out_valid : a_out_valid; endfunction
   function automatic logic ir(input bit b); return b ? b_in_ready : a_in_ready; endfunction
   function automatic int qs(input bit b); return b ? qb.size() : qa.size(); endfunction

   task automatic drive(input bit b, input logic vld, input logic [31:0] dt, input int sh, input logic [1:0] op, input int tag);
      if (b) begin
         b_in_valid = vld; b_in_data = dt[7:0]; b_in_shamt = 3'(sh); b_in_op = op; b_in_tag = TW'(tag);
      end else begin
         a_in_valid = vld; a_in_data = dt; a_in_shamt = 5'(sh); a_in_op = op; a_in_tag = TW'(tag);
      end
   endtask

   task automatic set_ready(input bit b, input logic r);
      if (b) b_out_ready = r; else a_out_ready = r;
   endtask

   // Scoreboards: push on accepted input, pop and compare on accepted output, check held output.
   logic a_hold, b_hold;
   logic [31:0] a_hd, b_hd;
   always @(negedge clk) begin
      if (rst) a_hold = 0;
      else begin
         if (a_hold) begin
            check("a_held_valid", 32'(a_out_valid), 1);
            check("a_held_data", a_out_data, a_hd);
         end
         a_hold = a_out_valid && !a_out_ready;
         a_hd = a_out_data;
         if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
               tests++; fails++;
               $display("FAIL a_spurious: got output %h, expected none", a_out_data);
            end else begin
               ea = qa.pop_front();
               check("a_data", a_out_data, ea.d);
               check("a_tag", 32'(a_out_tag), 32'(ea.t));
            end
         end
         if (a_in_valid && a_in_ready) qa.push_back('{ref_shift(a_in_data, int'(a_in_shamt), a_in_op, 32), a_in_tag});
      end
   end
   always @(negedge clk) begin
      if (rst) b_hold = 0;
      else begin
         if (b_hold) begin
            check("b_held_valid", 32'(b_out_valid), 1);
            check("b_held_data", 32'(b_out_data), b_hd);
         end
         b_hold = b_out_valid && !b_out_ready;
         b_hd = 32'(b_out_data);
         if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
               tests++; fails++;
               $display("FAIL b_spurious: got output %h, expected none", b_out_data);
            end else begin
               eb = qb.pop_front();
               check("b_data", 32'(b_out_data), eb.d);
               check("b_tag", 32'(b_out_tag), 32'(eb.t));
            end
         end
         if (b_in_valid && b_in_ready) qb.push_back('{ref_shift(32'(b_in_data), int'(b_in_shamt), b_in_op, 8), b_in_tag});
      end
   end

   task automatic drain(input bit b);
      int n;
      n = 0;
      while ((qs(b) != 0 || ov(b)) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check(b ? "b_drain" : "a_drain", 32'(qs(b)), 0);
   endtask

   task automatic run_vec(input vec_t x, input int tag);
      int n, lat;
      lat = x.b ? 1 : 5;
      set_ready(x.b, 1);
      drive(x.b, 1, x.d, x.sh, x.op, tag);
      @(negedge clk);
      check("vec_in_ready", 32'(ir(x.b)), 1);
      @(posedge clk); #1;
      drive(x.b, 0, 0, 0, 0, 0);
      n = 0;
      while (!ov(x.b) && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check("vec_latency", 32'(n + 1), 32'(lat));
      check("vec_data", x.b ? 32'(b_out_data) : a_out_data, x.exp);
      check("vec_tag", x.b ? 32'(b_out_tag) : 32'(a_out_tag), 32'(TW'(tag)));
      @(posedge clk); #1;
   endtask

   task automatic stream(input bit b);
      int stalls, w;
      stalls = 0;
      w = b ? 8 : 32;
      set_ready(b, 1);
      for (int i = 0; i < 64; i++) begin
         drive(b, 1, $urandom, $urandom_range(0, w - 1), 2'($urandom_range(0, 3)), i);
         @(negedge clk);
         if (!ir(b)) stalls++;
         @(posedge clk); #1;
      end
      drive(b, 0, $urandom, 0, 0, 0);
      check(b ? "b_stream_stalls" : "a_stream_stalls", 32'(stalls), 0);
      drain(b);
   endtask

   task automatic backpressure(input bit b);
      int acc;
      acc = 0;
      set_ready(b, 0);
      for (int i = 0; i < 10; i++) begin
         drive(b, 1, $urandom, $urandom_range(0, b ? 7 : 31), 2'($urandom_range(0, 3)), 40 + i);
         @(negedge clk);
         if (ir(b)) acc++;
         @(posedge clk); #1;
      end
      check(b ? "b_bp_accepted" : "a_bp_accepted", 32'(acc), b ? 1 : 5);
      check(b ? "b_bp_in_ready" : "a_bp_in_ready", 32'(ir(b)), 0);
      drive(b, 0, 0, 0, 0, 0);
      set_ready(b, 1);
      drain(b);
   endtask

   task automatic random_phase(input bit b);
      int w;
      w = b ? 8 : 32;
      for (int i = 0; i < 150; i++) begin
         drive(b, $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, w - 1), 2'($urandom_range(0, 3)), i);
         set_ready(b, $urandom_range(0, 9) < 6);
         @(posedge clk); #1;
      end
      drive(b, 0, $urandom, 0, 0, 0);
      set_ready(b, 1);
      drain(b);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      vt = '{
         '{1'b0, 32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF},
         '{1'b0, 32'h8000_0000, 31, 2'b01, 32'h0000_0001},
         '{1'b0, 32'h1234_5678,  8, 2'b11, 32'h7812_3456},
         '{1'b0, 32'h1234_5678,  8, 2'b00, 32'h3456_7800},
         '{1'b0, 32'h1234_5678,  0, 2'b00, 32'h1234_5678},
         '{1'b0, 32'h1234_5678,  0, 2'b01, 32'h1234_5678},
         '{1'b0, 32'h1234_5678,  0, 2'b10, 32'h1234_5678},
         '{1'b0, 32'h1234_5678,  0, 2'b11, 32'h1234_5678},
         '{1'b0, 32'h1234_5678,  8, 2'b01, 32'h0012_3456},
         '{1'b0, 32'h8000_0000,  4, 2'b10, 32'hF800_0000},
         '{1'b0, 32'h0000_0001, 31, 2'b00, 32'h8000_0000},
         '{1'b0, 32'h0000_0001,  1, 2'b11, 32'h8000_0000},
         '{1'b0, 32'h7FFF_FFFF,  4, 2'b10, 32'h07FF_FFFF},
         '{1'b1, 32'h0000_0080,  7, 2'b10, 32'h0000_00FF},
         '{1'b1, 32'h0000_0080,  7, 2'b01, 32'h0000_0001},
         '{1'b1, 32'h0000_0096,  4, 2'b11, 32'h0000_0069},
         '{1'b1, 32'h0000_0096,  3, 2'b00, 32'h0000_00B0},
         '{1'b1, 32'h0000_0096,  2, 2'b10, 32'h0000_00E5},
         '{1'b1, 32'h0000_005A,  0, 2'b11, 32'h0000_005A},
         '{1'b1, 32'h0000_0001,  7, 2'b11, 32'h0000_0002}};
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      a_out_ready = 1;
      b_out_ready = 1;
      #1 rst = 1;
      #1;
      check("a_rst_valid", 32'(a_out_valid), 0);
      check("a_rst_data", a_out_data, 0);
      check("a_rst_tag", 32'(a_out_tag), 0);
      check("b_rst_valid", 32'(b_out_valid), 0);
      check("b_rst_data", 32'(b_out_data), 0);
      check("b_rst_tag", 32'(b_out_tag), 0);
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      check("a_rst_in_ready", 32'(a_in_ready), 1);
      check("b_rst_in_ready", 32'(b_in_ready), 1);
      @(posedge clk); #1;
      foreach (vt[i]) run_vec(vt[i], i);
      for (int b = 0; b < 2; b++) begin
         stream(b[0]);
         backpressure(b[0]);
         random_phase(b[0]);
      end
      run_vec(vt[0], 1);
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, $urandom, $urandom_range(1, 31), 2'($urandom_range(0, 3)), 50 + i);
         @(posedge clk); #1;
      end
      drive(0, 0, 0, 0, 0, 0);
      #1 rst = 1;
      qa.delete();
      qb.delete();
      #1;
      check("mid_rst_valid", 32'(a_out_valid), 0);
      check("mid_rst_data", a_out_data, 0);
      check("mid_rst_tag", 32'(a_out_tag), 0);
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      check("mid_rst_in_ready", 32'(a_in_ready), 1);
      @(posedge clk); #1;
      run_vec(vt[2], 9);
      drain(0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
